// File: rtl/hdc_assoc_search_pkg.sv
// rtl/hdc_assoc_search_pkg.sv - shared widths, counts and FSM encoding for the associative search stage
package hdc_assoc_search_pkg;

    localparam int FRAME_W   = 64;
    localparam int N_FRAMES  = 3;
    localparam int N_CLASSES = 8;
    localparam int CID_W     = 3;
    localparam int FIDX_W    = 2;
    localparam int DIST_W    = 8;
    localparam int PC_W      = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/hdc_assoc_search_if.sv
// rtl/hdc_assoc_search_if.sv - query, class ROM and result signals of the search stage
interface hdc_assoc_search_if;
    import hdc_assoc_search_pkg::*;

    logic               q_valid;
    logic               q_ready;
    logic [FRAME_W-1:0] q_frame;
    logic [CID_W-1:0]   cls_frame_id;
    logic [FIDX_W-1:0]  cls_frame_index;
    logic [FRAME_W-1:0] cls_vec_in;
    logic               result_valid;
    logic               result_ready;
    logic [CID_W-1:0]   result_class;
    logic [DIST_W-1:0]  result_dist;

    modport slave (
        input  q_valid, q_frame, cls_vec_in, result_ready,
        output q_ready, cls_frame_id, cls_frame_index,
        output result_valid, result_class, result_dist
    );

    modport master (
        output q_valid, q_frame, cls_vec_in, result_ready,
        input  q_ready, cls_frame_id, cls_frame_index,
        input  result_valid, result_class, result_dist
    );

endinterface

// File: rtl/hdc_assoc_search_popcount.sv
// rtl/hdc_assoc_search_popcount.sv - combinational population count of one hypervector frame
module hvec_popcount #(
    parameter int W    = 64,
    parameter int OUTW = $clog2(W + 1)
) (
    input  logic [W-1:0]    word_i,
    output logic [OUTW-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + OUTW'(word_i[i]);
        end
    end

endmodule

// File: rtl/hdc_assoc_search.sv
// rtl/hdc_assoc_search.sv - buffers a query hypervector, sweeps the class ROM and reports the nearest class
module hdc_assoc_search
    import hdc_assoc_search_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    hdc_assoc_search_if.slave bus
);

    localparam logic [FIDX_W-1:0] LAST_F = FIDX_W'(N_FRAMES - 1);
    localparam logic [CID_W-1:0]  LAST_C = CID_W'(N_CLASSES - 1);

    state_e              state_q, state_d;
    logic [FIDX_W-1:0]   ld_cnt_q, ld_cnt_d;
    logic [FRAME_W-1:0]  qbuf_q [N_FRAMES];
    logic [FRAME_W-1:0]  qbuf_d [N_FRAMES];
    logic [CID_W-1:0]    c_q, c_d;
    logic [FIDX_W-1:0]   f_q, f_d;
    logic [DIST_W-1:0]   acc_q, acc_d;
    logic [DIST_W-1:0]   best_dist_q, best_dist_d;
    logic [CID_W-1:0]    best_class_q, best_class_d;

    logic [FRAME_W-1:0]  qsel;
    logic [PC_W-1:0]     pc;
    logic [DIST_W-1:0]   total;

    // Explicit mux keeps the 2-bit frame pointer from indexing past the 3-entry buffer.
    always_comb begin
        qsel = '0;
        for (int i = 0; i < N_FRAMES; i++) begin
            if (f_q == FIDX_W'(i)) qsel = qbuf_q[i];
        end
    end

    hvec_popcount #(.W(FRAME_W), .OUTW(PC_W)) u_popcount (
        .word_i  (qsel ^ bus.cls_vec_in),
        .count_o (pc)
    );

    assign total = (f_q == '0) ? DIST_W'(pc) : acc_q + DIST_W'(pc);

    always_comb begin
        state_d      = state_q;
        ld_cnt_d     = ld_cnt_q;
        qbuf_d       = qbuf_q;
        c_d          = c_q;
        f_d          = f_q;
        acc_d        = acc_q;
        best_dist_d  = best_dist_q;
        best_class_d = best_class_q;
        unique case (state_q)
            ST_LOAD: begin
                if (bus.q_valid) begin
                    for (int i = 0; i < N_FRAMES; i++) begin
                        if (ld_cnt_q == FIDX_W'(i)) qbuf_d[i] = bus.q_frame;
                    end
                    ld_cnt_d = ld_cnt_q + FIDX_W'(1);
                    if (ld_cnt_q == LAST_F) begin
                        state_d      = ST_SEARCH;
                        ld_cnt_d     = '0;
                        c_d          = '0;
                        f_d          = '0;
                        best_dist_d  = '1;
                        best_class_d = '0;
                    end
                end
            end
            ST_SEARCH: begin
                acc_d = total;
                if (f_q == LAST_F) begin
                    // Strict compare: on a tie the earlier (lower) class stays.
                    if (total < best_dist_q) begin
                        best_dist_d  = total;
                        best_class_d = c_q;
                    end
                    f_d = '0;
                    c_d = c_q + CID_W'(1);
                    if (c_q == LAST_C) state_d = ST_DONE;
                end else begin
                    f_d = f_q + FIDX_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.result_ready) begin
                    state_d  = ST_LOAD;
                    ld_cnt_d = '0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            ld_cnt_q     <= '0;
            qbuf_q       <= '{default: '0};
            c_q          <= '0;
            f_q          <= '0;
            acc_q        <= '0;
            best_dist_q  <= '1;
            best_class_q <= '0;
        end else begin
            state_q      <= state_d;
            ld_cnt_q     <= ld_cnt_d;
            qbuf_q       <= qbuf_d;
            c_q          <= c_d;
            f_q          <= f_d;
            acc_q        <= acc_d;
            best_dist_q  <= best_dist_d;
            best_class_q <= best_class_d;
        end
    end

    assign bus.q_ready         = (state_q == ST_LOAD);
    assign bus.result_valid    = (state_q == ST_DONE);
    assign bus.result_class    = best_class_q;
    assign bus.result_dist     = best_dist_q;
    assign bus.cls_frame_id    = c_q;
    assign bus.cls_frame_index = f_q;

endmodule

// File: tb/tb_hdc_assoc_search.sv
// tb/tb_hdc_assoc_search.sv - directed bench for the associative search stage
module tb_hdc_assoc_search;
    import hdc_assoc_search_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   t_last = 0;
    int   lat;
    int   rom_mode = 0;

    hdc_assoc_search_if bus ();

    hdc_assoc_search dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] hv(input int c, input int f);
        logic [63:0] x;
        x = 64'(c * 3 + f + 1) * 64'h9E3779B97F4A7C15;
        x = x ^ (x >> 31);
        x = x * 64'hBF58476D1CE4E5B9;
        x = x ^ (x >> 27);
        return x;
    endfunction

    // ROM model: 0 = hashed class vectors, 1 = classes 2 and 5 identical, 2 = all ones
    always_comb begin
        case (rom_mode)
            1:       bus.cls_vec_in = (bus.cls_frame_id == 3'd5) ? hv(2, int'(bus.cls_frame_index))
                                                                 : hv(int'(bus.cls_frame_id), int'(bus.cls_frame_index));
            2:       bus.cls_vec_in = '1;
            default: bus.cls_vec_in = hv(int'(bus.cls_frame_id), int'(bus.cls_frame_index));
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_query(input logic [63:0] f0, input logic [63:0] f1, input logic [63:0] f2);
        logic [63:0] fr [3];
        fr[0] = f0; fr[1] = f1; fr[2] = f2;
        for (int k = 0; k < 3; k++) begin
            bus.q_valid = 1'b1;
            bus.q_frame = fr[k];
            if (k == 2) t_last = cyc;
            step();
        end
        bus.q_valid = 1'b0;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!bus.result_valid && n < 200) begin
            step();
            n++;
            if (bus.cls_frame_index == 2'd3) begin
                n_err++;
                $error("FAIL idx_range observed=3 expected<3");
            end
        end
        lat = cyc - t_last;
    endtask

    task automatic release_result();
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
        chk("rel_valid", 64'(bus.result_valid), 64'd0);
        chk("rel_qready", 64'(bus.q_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus.q_valid = 1'b0;
        bus.q_frame = '0;
        bus.result_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        chk("rst_qready", 64'(bus.q_ready), 64'd1);
        chk("rst_valid", 64'(bus.result_valid), 64'd0);
        chk("rst_class", 64'(bus.result_class), 64'd0);
        chk("rst_dist", 64'(bus.result_dist), 64'hFF);
        chk("rst_id", 64'(bus.cls_frame_id), 64'd0);
        chk("rst_idx", 64'(bus.cls_frame_index), 64'd0);

        // exact match with class 3, pointer walk and latency
        rom_mode = 0;
        send_query(hv(3, 0), hv(3, 1), hv(3, 2));
        chk("t1_qready_search", 64'(bus.q_ready), 64'd0);
        chk("t1_id0", 64'(bus.cls_frame_id), 64'd0);
        chk("t1_idx0", 64'(bus.cls_frame_index), 64'd0);
        step();
        chk("t1_idx1", 64'(bus.cls_frame_index), 64'd1);
        step();
        chk("t1_idx2", 64'(bus.cls_frame_index), 64'd2);
        step();
        chk("t1_id1", 64'(bus.cls_frame_id), 64'd1);
        chk("t1_idx_wrap", 64'(bus.cls_frame_index), 64'd0);
        wait_result();
        chk("t1_latency", 64'(lat), 64'd25);
        chk("t1_class", 64'(bus.result_class), 64'd3);
        chk("t1_dist", 64'(bus.result_dist), 64'd0);
        release_result();

        // class 4 with five bits flipped in frame 1
        send_query(hv(4, 0), hv(4, 1) ^ 64'h8000_0100_0000_0013, hv(4, 2));
        wait_result();
        chk("t2_latency", 64'(lat), 64'd25);
        chk("t2_class", 64'(bus.result_class), 64'd4);
        chk("t2_dist", 64'(bus.result_dist), 64'd5);
        release_result();

        // tie between classes 2 and 5
        rom_mode = 1;
        send_query(hv(2, 0), hv(2, 1), hv(2, 2));
        wait_result();
        chk("t3_class", 64'(bus.result_class), 64'd2);
        chk("t3_dist", 64'(bus.result_dist), 64'd0);
        release_result();

        // all-ones ROM against zero query: every class at 192
        rom_mode = 2;
        send_query(64'd0, 64'd0, 64'd0);
        wait_result();
        chk("t4_latency", 64'(lat), 64'd25);
        chk("t4_class", 64'(bus.result_class), 64'd0);
        chk("t4_dist", 64'(bus.result_dist), 64'hC0);

        // back-pressure in DONE with q_valid asserted
        bus.q_valid = 1'b1;
        bus.q_frame = 64'hDEAD_BEEF_0000_FFFF;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_valid", 64'(bus.result_valid), 64'd1);
            chk("t5_class", 64'(bus.result_class), 64'd0);
            chk("t5_dist", 64'(bus.result_dist), 64'hC0);
            chk("t5_qready", 64'(bus.q_ready), 64'd0);
        end
        bus.q_valid = 1'b0;
        release_result();

        // reset in search cycle 10, then a fresh query
        rom_mode = 0;
        send_query(hv(6, 0), hv(6, 1), hv(6, 2));
        repeat (9) step();
        chk("t6_in_search", 64'(bus.q_ready), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_qready", 64'(bus.q_ready), 64'd1);
        chk("t6_valid", 64'(bus.result_valid), 64'd0);
        chk("t6_id", 64'(bus.cls_frame_id), 64'd0);
        chk("t6_idx", 64'(bus.cls_frame_index), 64'd0);
        chk("t6_dist", 64'(bus.result_dist), 64'hFF);
        send_query(hv(1, 0), hv(1, 1), hv(1, 2));
        wait_result();
        chk("t6_latency", 64'(lat), 64'd25);
        chk("t6_class", 64'(bus.result_class), 64'd1);
        chk("t6_res_dist", 64'(bus.result_dist), 64'd0);
        release_result();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
